instr_fetch: RTL and testbench

Instruction fetch stage that sits directly upstream of the `Pipeline` datapath and drives its `InstrIn` port. It holds a word-addressed instruction memory, advances a program counter, and buffers fetched words in a 2-entry prefetch FIFO so a downstream stall never loses an instruction. It inserts NOP bubbles (all-zero word) when nothing is valid, and supports PC redirect and a HALT opcode.

---
 rtl/pipeline_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/instr_fetch.sv | 100 ++++++++++
 tb/tb_instr_fetch.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: instruction word width, HALT opcode, NOP bubble
// and the instruction field positions.
package pipeline_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 26;
  localparam int unsigned WS1_MSB = 25;
  localparam int unsigned WS1_LSB = 21;
  localparam int unsigned RS1_MSB = 20;
  localparam int unsigned RS1_LSB = 16;
  localparam int unsigned RS2_MSB = 15;
  localparam int unsigned RS2_LSB = 11;
  localparam int unsigned IMM_MSB = 15;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [5:0]         OPC_HALT = 6'b111111;
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0;

  function automatic logic is_halt(input logic [INSTR_W-1:0] word);
    return word[OPC_MSB:OPC_LSB] == OPC_HALT;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry prefetch FIFO of {addr, instr}; slot0 is always the head.
module fetch_fifo
  import pipeline_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push,
  input  logic               pop,
  input  logic [ADDR_W-1:0]  push_addr,
  input  logic [INSTR_W-1:0] push_instr,
  output logic [ADDR_W-1:0]  head_addr,
  output logic [INSTR_W-1:0] head_instr,
  output logic [1:0]         count
);

  localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;

  logic [ENTRY_W-1:0] slot0;
  logic [ENTRY_W-1:0] slot1;
  logic [ENTRY_W-1:0] in_entry;

  assign in_entry   = {push_addr, push_instr};
  assign head_addr  = slot0[ENTRY_W-1:INSTR_W];
  assign head_instr = slot0[INSTR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= in_entry;
          else               slot1 <= in_entry;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // count unchanged; new entry lands behind whatever remains
          if (count == 2'd2) begin
            slot0 <= slot1;
            slot1 <= in_entry;
          end else begin
            slot0 <= in_entry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, synchronous read-first instruction memory,
// prefetch FIFO, redirect and HALT handling feeding Pipeline.InstrIn.
module instr_fetch
  import pipeline_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic [INSTR_W-1:0] InstrOut,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               halted
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  rd_addr;
  logic [INSTR_W-1:0] rd_data;
  logic               inflight;
  logic [1:0]         count;
  logic [ADDR_W-1:0]  head_addr;
  logic [INSTR_W-1:0] head_instr;
  logic               push;
  logic               pop;
  logic               halt_ret;
  logic               issue;
  logic               fetch_en;
  logic [ADDR_W-1:0]  fetch_addr;
  logic [2:0]         occupancy;

  // Occupancy nets out this cycle's dequeue so an unstalled stream sustains one word per cycle
  assign instr_valid = (count != 2'd0);
  assign pop         = instr_valid && !stall;
  assign push        = inflight && !redirect;
  assign halt_ret    = inflight && is_halt(rd_data);
  assign occupancy   = 3'(count) + 3'(inflight) - 3'(pop);
  assign issue       = !halted && !halt_ret && !redirect && (occupancy < 3'd2);

  // A redirect launches its own read of redirect_pc, so only one bubble follows it
  assign fetch_en    = issue || redirect;
  assign fetch_addr  = redirect ? redirect_pc : pc;

  assign InstrOut    = instr_valid ? head_instr : NOP_WORD;
  assign pc_out      = instr_valid ? head_addr : '0;

  // Memory write port and read-first data capture; contents survive reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= NOP_WORD;
      rd_addr <= '0;
    end else begin
      if (prog_we) mem[prog_addr] <= prog_data;
      if (fetch_en) begin
        rd_data <= mem[fetch_addr];
        rd_addr <= fetch_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= ADDR_W'(RESET_PC);
      inflight <= 1'b0;
      halted   <= 1'b0;
    end else begin
      inflight <= fetch_en;
      if (redirect) begin
        pc     <= redirect_pc + ADDR_W'(1);
        halted <= 1'b0;
      end else begin
        if (issue)    pc     <= pc + ADDR_W'(1);
        if (halt_ret) halted <= 1'b1;
      end
    end
  end

  fetch_fifo #(.ADDR_W(ADDR_W)) u_fifo (
    .clk        (clk),
    .rst_n      (rst),
    .flush      (redirect),
    .push       (push),
    .pop        (pop),
    .push_addr  (rd_addr),
    .push_instr (rd_data),
    .head_addr  (head_addr),
    .head_instr (head_instr),
    .count      (count)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, stall, redirect, HALT, async reset,
// read-first write collision, and PC wrap on a narrow instance.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst, stall, redirect, prog_we;
  logic [7:0]  redirect_pc, prog_addr, pc_out;
  logic [31:0] prog_data, instr_out;
  logic        instr_valid, halted;

  logic        w_rst, w_stall, w_redirect, w_prog_we;
  logic [1:0]  w_redirect_pc, w_prog_addr, w_pc_out;
  logic [31:0] w_prog_data, w_instr_out;
  logic        w_instr_valid, w_halted;

  int unsigned passed = 0;
  int unsigned total  = 0;

  logic [31:0] prog [4];
  logic [31:0] wmem [4];
  logic [31:0] wexp_instr [5];
  logic [1:0]  wexp_pc [5];

  localparam logic [31:0] W8      = 32'h6D66019D;
  localparam logic [31:0] NEW_W1  = 32'h12345678;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(8), .RESET_PC(0)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .InstrOut(instr_out), .instr_valid(instr_valid), .pc_out(pc_out), .halted(halted)
  );

  instr_fetch #(.ADDR_W(2), .RESET_PC(3)) u_wrap (
    .clk(clk), .rst(w_rst), .stall(w_stall), .redirect(w_redirect), .redirect_pc(w_redirect_pc),
    .prog_we(w_prog_we), .prog_addr(w_prog_addr), .prog_data(w_prog_data),
    .InstrOut(w_instr_out), .instr_valid(w_instr_valid), .pc_out(w_pc_out), .halted(w_halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    prog[0] = 32'h40410000; prog[1] = 32'h44620000;
    prog[2] = 32'h4D652800; prog[3] = 32'hFC000000;
    wmem[0] = 32'h0B000000; wmem[1] = 32'h0C000001;
    wmem[2] = 32'h0D000002; wmem[3] = 32'hA0000003;
    wexp_pc[0] = 2'd3; wexp_pc[1] = 2'd0; wexp_pc[2] = 2'd1; wexp_pc[3] = 2'd2; wexp_pc[4] = 2'd3;
    for (int k = 0; k < 5; k++) wexp_instr[k] = wmem[wexp_pc[k]];

    rst = 1'b0; stall = 1'b1; redirect = 1'b0; redirect_pc = '0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    w_rst = 1'b0; w_stall = 1'b0; w_redirect = 1'b0; w_redirect_pc = '0;
    w_prog_we = 1'b0; w_prog_addr = '0; w_prog_data = '0;
    tick(); tick();
    check("wrap_rst_instr", w_instr_out, 32'h0);
    check("wrap_rst_valid", 32'(w_instr_valid), 32'h0);
    check("wrap_rst_pc", 32'(w_pc_out), 32'h0);
    check("wrap_rst_halted", 32'(w_halted), 32'h0);

    // Load memories with non-HALT filler, then the program words
    rst = 1'b1; w_rst = 1'b1;
    for (int i = 0; i < 256; i++) begin
      prog_we = 1'b1; prog_addr = 8'(i); prog_data = 32'h01000000 + 32'(i);
      w_prog_we = (i < 4); w_prog_addr = 2'(i); w_prog_data = wmem[i % 4];
      tick();
    end
    w_prog_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      prog_addr = 8'(k); prog_data = prog[k];
      tick();
    end
    prog_addr = 8'd8; prog_data = W8;
    tick();
    prog_we = 1'b0;
    w_rst = 1'b0;

    // Async reset while the stalled FIFO holds valid words
    check("pre_rst_valid", 32'(instr_valid), 32'h1);
    rst = 1'b0;
    #1;
    check("async_rst_instr", instr_out, 32'h0);
    check("async_rst_valid", 32'(instr_valid), 32'h0);
    check("async_rst_pc", 32'(pc_out), 32'h0);
    check("async_rst_halted", 32'(halted), 32'h0);
    tick();

    // Free-running stream from RESET_PC into HALT
    stall = 1'b0; rst = 1'b1;
    check("c0_valid", 32'(instr_valid), 32'h0);
    tick();
    check("c1_valid", 32'(instr_valid), 32'h0);
    tick();
    for (int k = 0; k < 4; k++) begin
      check("run_instr", instr_out, prog[k]);
      check("run_pc", 32'(pc_out), 32'(k));
      check("run_valid", 32'(instr_valid), 32'h1);
      check("run_halted", 32'(halted), (k == 3) ? 32'h1 : 32'h0);
      tick();
    end
    check("halt_bubble_instr", instr_out, 32'h0);
    check("halt_bubble_valid", 32'(instr_valid), 32'h0);
    check("halt_bubble_pc", 32'(pc_out), 32'h0);
    check("halt_stays", 32'(halted), 32'h1);
    tick();
    check("halt_bubble2_valid", 32'(instr_valid), 32'h0);

    // Redirect out of HALT, then redirect again with a full stalled FIFO
    stall = 1'b1; redirect = 1'b1; redirect_pc = 8'd0;
    tick();
    redirect = 1'b0;
    check("redir0_bubble", 32'(instr_valid), 32'h0);
    check("redir0_halted_clr", 32'(halted), 32'h0);
    tick();
    check("redir0_instr", instr_out, prog[0]);
    check("redir0_pc", 32'(pc_out), 32'h0);
    tick();
    check("redir0_held", instr_out, prog[0]);
    redirect = 1'b1; redirect_pc = 8'd8;
    tick();
    redirect = 1'b0;
    check("redir8_bubble_valid", 32'(instr_valid), 32'h0);
    check("redir8_bubble_instr", instr_out, 32'h0);
    tick();
    check("redir8_instr", instr_out, W8);
    check("redir8_pc", 32'(pc_out), 32'h8);
    check("redir8_valid", 32'(instr_valid), 32'h1);

    // Stall from cycle 2 to 5, then drain back-to-back
    rst = 1'b0;
    tick();
    rst = 1'b1; stall = 1'b0;
    tick();
    tick();
    stall = 1'b1;
    check("stall_c2", instr_out, prog[0]);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_hold", instr_out, prog[0]);
      check("stall_hold_valid", 32'(instr_valid), 32'h1);
    end
    tick();
    stall = 1'b0;
    check("stall_release_head", instr_out, prog[0]);
    for (int k = 1; k < 4; k++) begin
      tick();
      check("drain_instr", instr_out, prog[k]);
      check("drain_pc", 32'(pc_out), 32'(k));
      check("drain_valid", 32'(instr_valid), 32'h1);
    end
    tick();
    check("drain_bubble", 32'(instr_valid), 32'h0);
    check("drain_halted", 32'(halted), 32'h1);

    // Write to the address being read in the same cycle
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    prog_we = 1'b1; prog_addr = 8'd1; prog_data = NEW_W1;
    tick();
    prog_we = 1'b0;
    check("coll_w0", instr_out, prog[0]);
    tick();
    check("coll_old_word", instr_out, prog[1]);
    check("coll_old_pc", 32'(pc_out), 32'h1);
    tick(); tick(); tick();
    check("coll_halt_bubble", 32'(instr_valid), 32'h0);
    redirect = 1'b1; redirect_pc = 8'd1;
    tick();
    redirect = 1'b0;
    check("coll_redir_bubble", 32'(instr_valid), 32'h0);
    tick();
    check("coll_new_word", instr_out, NEW_W1);
    check("coll_new_pc", 32'(pc_out), 32'h1);
    tick();
    check("coll_next_word", instr_out, prog[2]);
    check("coll_next_pc", 32'(pc_out), 32'h2);

    // Narrow instance: PC wraps 3 -> 0
    w_rst = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      check("wrap_pc", 32'(w_pc_out), 32'(wexp_pc[k]));
      check("wrap_instr", w_instr_out, wexp_instr[k]);
      check("wrap_valid", 32'(w_instr_valid), 32'h1);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
